line_repeater: RTL and testbench
================================

// Module: line_repeater
// PURPOSE
//  Ping-pong scanline buffer: the reader side of the decoded-pixel path. The
//  Y/C path writes a line in; this block plays each stored line back REPEAT
//  times over a valid/ready stream, which gives vertical line doubling for the
//  upscaler. It sits after the luma/chroma realignment stage and before the
//  output scaler/timing generator.
// PARAMETERS
//  DATA_WIDTH   12   signed pixel sample width
//  LINE_PIXELS  720  max pixels stored per line (per bank)
//  REPEAT       2    times each stored line is replayed (>=1)
//  ADDR_WIDTH   $clog2(LINE_PIXELS)  derived; do not override
//  REP_WIDTH    max(1,$clog2(REPEAT)) derived; do not override
// PORTS
//  clk          in   1           single clock
//  rst          in   1           synchronous, active-high reset
//  in_valid     in   1           in_data is a pixel this cycle (no backpressure)
//  in_data      in   DATA_WIDTH  signed pixel
//  in_eol       in   1           with in_valid: this pixel is last of its line
//  out_valid    out  1           out_data valid
//  out_ready    in   1           consumer accepts when out_valid&&out_ready
//  out_data     out  DATA_WIDTH  signed pixel, bit-exact copy of input
//  out_sol      out  1           first pixel of a repetition
//  out_eol      out  1           last pixel of a repetition
//  out_rep      out  REP_WIDTH   repetition index 0..REPEAT-1
//  overflow     out  1           sticky: a line exceeded LINE_PIXELS
//  line_dropped out  1           sticky: an input line was discarded
// BEHAVIOUR
//  - Reset: all outputs 0; both banks empty; wr_bank=0, rd bank=0, counters 0.
//    RAM contents are not cleared. Reset mid-line or mid-replay abandons it;
//    out_valid is 0 in the cycle after rst is sampled.
//  - Write: on in_valid, write to wr_bank[wr_addr], then wr_addr++. Pixels with
//    wr_addr>=LINE_PIXELS are discarded and overflow is set. On in_valid&&in_eol,
//    store len=min(wr_addr+1,LINE_PIXELS), set full[wr_bank], toggle wr_bank,
//    and set wr_addr=0. Minimum line length is 1.
//  - Drop: the first pixel of a line checks full[wr_bank]. If it is set, the
//    whole line up to and including in_eol is ignored and line_dropped is set.
//    If the reader clears that full flag in the same cycle, the clear wins and
//    the line is accepted.
//  - Read FSM: IDLE -> PLAY when full[rd_bank]. PLAY walks addr 0..len-1 for
//    rep 0..REPEAT-1. After the last beat of the last rep is accepted, clear
//    full[rd_bank] and toggle rd_bank. Go to PLAY if the new bank is full,
//    otherwise go to IDLE.
//  - Latency: eol accepted at cycle T -> out_valid first high at T+2 (reader idle).
//  - Throughput: with out_ready held at 1, there are no bubbles within a line or
//    between repetitions. There are at most 2 idle cycles between lines.
//  - Handshake: while out_valid&&!out_ready, out_data/sol/eol/rep are held
//    stable. out_valid never drops without acceptance. No beat is lost or
//    duplicated. The RAM has 1-cycle read latency; use a 2-entry skid/prefetch.
//  - out_sol=1 on addr 0 of each rep. out_eol=1 on addr len-1. For len=1 both
//    are 1 on the same beat.
//  - A writer may fill the free bank while the reader plays the other one.
//    Read and write addresses never target the same bank in the same cycle.
// STRUCTURE
//  - The shared package video_pkg holds typedef pixel_t (logic signed
//    [DATA_WIDTH-1:0]) and the read FSM enum rd_state_t {IDLE, PLAY}.
//  - Sub-module line_ram: simple dual-port, depth 2*LINE_PIXELS, one write port
//    and one registered read port. The bank select is the address MSB.
//    Instantiate it once.
// TESTING
//  1. 4-pixel line 10,20,30,40+eol, out_ready=1 -> out_data is 10,20,30,40,
//     10,20,30,40. sol is set on each 10 and eol on each 40; out_rep is 0,0,0,0
//     then 1,1,1,1.
//  2. Same line, out_ready toggling 1,0,1,0 -> the same 8 beats, and out_data
//     stays stable on every stalled cycle.
//  3. Three back-to-back 4-pixel lines (A,B,C), out_ready=0 -> A and B are stored,
//     C is dropped, line_dropped=1. Then ready=1 -> A x2, B x2, nothing more.
//  4. LINE_PIXELS=8, a 10-pixel line 1..10+eol -> each rep outputs 1..8 with
//     eol on 8; overflow=1.
//  5. rst pulse during rep 0 at pixel 2 -> out_valid=0 next cycle and both
//     stickies are 0. A new 3-pixel line 5,6,7 then replays correctly.
//  6. Pixels -2048, 2047, 0 with len=3 -> the same values are replayed
//     bit-exact, twice.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types for the decoded-pixel path: sample type and line-reader FSM states.
package video_pkg;

   localparam int PIXEL_WIDTH = 12;

   typedef logic signed [PIXEL_WIDTH-1:0] pixel_t;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } rd_state_t;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line store: one write port and one registered read port.
// The top address bit selects the bank; each bank is padded to a power of two.
module line_ram #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         o_rdata <= r_mem[i_raddr];
      end
   end

endmodule

// File: rtl/line_repeater.sv
// Ping-pong scanline buffer: stores incoming lines in two banks and replays each
// stored line REPEAT times on a valid/ready stream (vertical line doubling).
module line_repeater
   import video_pkg::*;
#(
   parameter int DATA_WIDTH  = 12,
   parameter int LINE_PIXELS = 720,
   parameter int REPEAT      = 2,
   parameter int ADDR_WIDTH  = $clog2(LINE_PIXELS),
   parameter int REP_WIDTH   = (REPEAT > 1) ? $clog2(REPEAT) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   input  logic                         in_eol,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic                         out_sol,
   output logic                         out_eol,
   output logic [REP_WIDTH-1:0]         out_rep,
   output logic                         overflow,
   output logic                         line_dropped
);

   localparam int                   LW       = ADDR_WIDTH + 1;
   localparam logic [LW-1:0]        LP       = LW'(LINE_PIXELS);
   localparam logic [REP_WIDTH-1:0] REP_LAST = REP_WIDTH'(REPEAT - 1);

   // Output stream: out_valid && out_ready is a transfer; while out_valid is high
   // and out_ready is low, the beat (data/sol/eol/rep) is held unchanged.

   // ---------------- write side ----------------
   logic            r_wr_bank;
   logic [LW-1:0]   r_wr_cnt;
   logic            r_dropping;
   logic [1:0]      r_full;
   logic [LW-1:0]   r_len [2];
   logic            r_overflow;
   logic            r_line_dropped;

   logic            w_room;
   logic            w_first;
   logic            w_bank_busy;
   logic            w_drop_px;
   logic            w_acc_px;
   logic            w_we;

   // ---------------- read side ----------------
   rd_state_t                      r_state;
   rd_state_t                      w_next_state;
   logic                           r_rd_bank;
   logic [ADDR_WIDTH-1:0]          r_rd_addr;
   logic [REP_WIDTH-1:0]           r_rd_rep;
   logic                           r_issued_all;
   logic                           r_pend;
   logic                           r_pend_sol;
   logic                           r_pend_eol;
   logic [REP_WIDTH-1:0]           r_pend_rep;
   logic signed [DATA_WIDTH-1:0]   r_fd [2];
   logic                           r_fs [2];
   logic                           r_fe [2];
   logic [REP_WIDTH-1:0]           r_fr [2];
   logic                           r_wp;
   logic                           r_rp;
   logic [1:0]                     r_cnt;

   logic signed [DATA_WIDTH-1:0]   w_ram_q;
   logic [LW-1:0]                  w_len;
   logic                           w_active;
   logic                           w_valid;
   logic                           w_pop;
   logic                           w_issue;
   logic                           w_addr_last;
   logic                           w_push;
   logic                           w_fifo_pop;
   logic                           w_last_acc;
   logic signed [DATA_WIDTH-1:0]   w_head_data;
   logic                           w_head_sol;
   logic                           w_head_eol;
   logic [REP_WIDTH-1:0]           w_head_rep;

   // The reader freeing this bank in the same cycle lets the new line in.
   always_comb begin
      w_room      = (r_wr_cnt < LP);
      w_first     = (r_wr_cnt == '0) && !r_dropping;
      w_bank_busy = r_full[r_wr_bank] && !(w_last_acc && (r_rd_bank == r_wr_bank));
      w_drop_px   = in_valid && (r_dropping || (w_first && w_bank_busy));
      w_acc_px    = in_valid && !w_drop_px;
      w_we        = w_acc_px && w_room;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_bank      <= 1'b0;
         r_wr_cnt       <= '0;
         r_dropping     <= 1'b0;
         r_full         <= '0;
         r_len[0]       <= '0;
         r_len[1]       <= '0;
         r_overflow     <= 1'b0;
         r_line_dropped <= 1'b0;
      end else begin
         if (w_drop_px) begin
            r_line_dropped <= 1'b1;
            r_dropping     <= !in_eol;
         end
         if (w_acc_px) begin
            if (!w_room) begin
               r_overflow <= 1'b1;
            end
            if (in_eol) begin
               r_len[r_wr_bank] <= w_room ? (r_wr_cnt + LW'(1)) : LP;
               r_wr_bank        <= ~r_wr_bank;
               r_wr_cnt         <= '0;
            end else if (w_room) begin
               r_wr_cnt <= r_wr_cnt + LW'(1);
            end
         end
         // Set is applied after clear so a 1-pixel line accepted on the free cycle sticks.
         for (int b = 0; b < 2; b++) begin
            if (w_last_acc && (r_rd_bank == 1'(b))) begin
               r_full[b] <= 1'b0;
            end
            if (w_acc_px && in_eol && (r_wr_bank == 1'(b))) begin
               r_full[b] <= 1'b1;
            end
         end
      end
   end

   line_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH + 1)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr ({r_wr_bank, r_wr_cnt[ADDR_WIDTH-1:0]}),
      .i_wdata (in_data),
      .i_re    (w_issue),
      .i_raddr ({r_rd_bank, r_rd_addr}),
      .o_rdata (w_ram_q)
   );

   // The RAM output register acts as the stage ahead of the 2-entry skid FIFO;
   // a read is issued only if the beat will have a slot once it arrives.
   always_comb begin
      w_len       = r_len[r_rd_bank];
      w_active    = (r_state == PLAY) || r_full[r_rd_bank];
      w_valid     = (r_cnt != 2'd0) || r_pend;
      w_pop       = w_valid && out_ready;
      w_issue     = w_active && !r_issued_all &&
                    ((3'(r_cnt) + 3'(r_pend)) < (3'd2 + 3'(w_pop)));
      w_addr_last = ((LW'(r_rd_addr) + LW'(1)) == w_len);
      if (r_cnt != 2'd0) begin
         w_head_data = r_fd[r_rp];
         w_head_sol  = r_fs[r_rp];
         w_head_eol  = r_fe[r_rp];
         w_head_rep  = r_fr[r_rp];
      end else begin
         w_head_data = w_ram_q;
         w_head_sol  = r_pend_sol;
         w_head_eol  = r_pend_eol;
         w_head_rep  = r_pend_rep;
      end
      w_last_acc  = w_pop && w_head_eol && (w_head_rep == REP_LAST);
      w_push      = r_pend && !((r_cnt == 2'd0) && w_pop);
      w_fifo_pop  = w_pop && (r_cnt != 2'd0);
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (r_full[r_rd_bank]) begin
               w_next_state = PLAY;
            end
         end
         PLAY: begin
            if (w_last_acc) begin
               w_next_state = r_full[~r_rd_bank] ? PLAY : IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_rd_bank    <= 1'b0;
         r_rd_addr    <= '0;
         r_rd_rep     <= '0;
         r_issued_all <= 1'b0;
         r_pend       <= 1'b0;
         r_pend_sol   <= 1'b0;
         r_pend_eol   <= 1'b0;
         r_pend_rep   <= '0;
         r_wp         <= 1'b0;
         r_rp         <= 1'b0;
         r_cnt        <= 2'd0;
      end else begin
         r_state <= w_next_state;
         r_pend  <= w_issue;
         if (w_issue) begin
            r_pend_sol <= (r_rd_addr == '0);
            r_pend_eol <= w_addr_last;
            r_pend_rep <= r_rd_rep;
         end
         if (w_last_acc) begin
            r_rd_bank    <= ~r_rd_bank;
            r_rd_addr    <= '0;
            r_rd_rep     <= '0;
            r_issued_all <= 1'b0;
         end else if (w_issue) begin
            if (w_addr_last) begin
               r_rd_addr <= '0;
               if (r_rd_rep == REP_LAST) begin
                  r_issued_all <= 1'b1;
               end else begin
                  r_rd_rep <= r_rd_rep + REP_WIDTH'(1);
               end
            end else begin
               r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
            end
         end
         if (w_push) begin
            r_fd[r_wp] <= w_ram_q;
            r_fs[r_wp] <= r_pend_sol;
            r_fe[r_wp] <= r_pend_eol;
            r_fr[r_wp] <= r_pend_rep;
            r_wp       <= ~r_wp;
         end
         if (w_fifo_pop) begin
            r_rp <= ~r_rp;
         end
         r_cnt <= r_cnt + 2'(w_push) - 2'(w_fifo_pop);
      end
   end

   always_comb begin
      out_valid    = w_valid;
      out_data     = w_valid ? w_head_data : '0;
      out_sol      = w_valid && w_head_sol;
      out_eol      = w_valid && w_head_eol;
      out_rep      = w_valid ? w_head_rep : '0;
      overflow     = r_overflow;
      line_dropped = r_line_dropped;
   end

endmodule

// File: tb/tb_line_repeater.sv
// Scoreboard bench for line_repeater (8-pixel banks, 2 repeats): directed cases
// followed by random lines and random backpressure against a line-level model.
module tb_line_repeater;
   import video_pkg::*;

   localparam int DW  = 12;
   localparam int LP  = 8;
   localparam int REP = 2;
   localparam int RW  = 1;
   localparam int BW  = DW + 2 + RW;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic signed [DW-1:0] in_data;
   logic                 in_eol;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] out_data;
   logic                 out_sol;
   logic                 out_eol;
   logic [RW-1:0]        out_rep;
   logic                 overflow;
   logic                 line_dropped;

   int checks   = 0;
   int failures = 0;

   // Reference model: lines waiting for replay and the beats they must produce.
   logic [BW-1:0] exp_q[$];
   int            stored_len[$];
   int            consumed;
   pixel_t        cur[$];
   logic          in_line;
   logic          line_ok;
   logic          exp_ovf;
   logic          exp_drop;
   logic          prev_stall;
   logic [BW-1:0] prev_beat;

   pixel_t        line_buf[16];
   int            ready_mode;
   logic          ready_level;

   line_repeater #(
      .DATA_WIDTH  (DW),
      .LINE_PIXELS (LP),
      .REPEAT      (REP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_eol       (in_eol),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_sol      (out_sol),
      .out_eol      (out_eol),
      .out_rep      (out_rep),
      .overflow     (overflow),
      .line_dropped (line_dropped)
   );

   initial forever #5 clk = ~clk;

   // Consumer: 0 = hold ready_level, 1 = toggle every cycle, 2 = random.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1:       out_ready = ~out_ready;
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = ready_level;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic push_line();
      logic [BW-1:0] b;
      int n;
      n = cur.size();
      for (int r = 0; r < REP; r++) begin
         for (int i = 0; i < n; i++) begin
            b = {cur[i], 1'(i == 0), 1'(i == n - 1), RW'(r)};
            exp_q.push_back(b);
         end
      end
      stored_len.push_back(n);
   endtask

   // Monitor: samples each cycle at the falling edge, checks, then updates the model.
   always @(negedge clk) begin : monitor
      logic [BW-1:0] act;
      logic [BW-1:0] e;
      act = {out_data, out_sol, out_eol, out_rep};
      if (rst) begin
         exp_q.delete();
         stored_len.delete();
         cur.delete();
         consumed   = 0;
         in_line    = 1'b0;
         line_ok    = 1'b0;
         exp_ovf    = 1'b0;
         exp_drop   = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!out_valid || act !== prev_beat) begin
               failures++;
               $display("FAIL hold: got valid=%0b beat=%h, required valid=1 beat=%h",
                        out_valid, act, prev_beat);
            end
         end
         checks++;
         if ({overflow, line_dropped} !== {exp_ovf, exp_drop}) begin
            failures++;
            $display("FAIL flags: got overflow=%0b line_dropped=%0b, required %0b %0b",
                     overflow, line_dropped, exp_ovf, exp_drop);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL beat: got unexpected data=%0d, required no beat", out_data);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  failures++;
                  $display("FAIL beat: got data=%0d sol=%0b eol=%0b rep=%0d, required data=%0d sol=%0b eol=%0b rep=%0d",
                           out_data, out_sol, out_eol, out_rep,
                           $signed(e[BW-1 -: DW]), e[RW+1], e[RW], e[RW-1:0]);
               end
               consumed++;
               if (consumed == stored_len[0] * REP) begin
                  void'(stored_len.pop_front());
                  consumed = 0;
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_beat  = act;
         if (in_valid) begin
            if (!in_line) begin
               in_line = 1'b1;
               cur.delete();
               line_ok = (stored_len.size() < 2);
               if (!line_ok) exp_drop = 1'b1;
            end
            if (line_ok) begin
               if (cur.size() >= LP) exp_ovf = 1'b1;
               else cur.push_back(in_data);
            end
            if (in_eol) begin
               in_line = 1'b0;
               if (line_ok) push_line();
            end
         end
      end
   end

   task automatic send_line(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         in_data  = line_buf[i];
         in_eol   = (i == n - 1);
      end
   endtask

   task automatic idle_in();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_eol   = 1'b0;
      in_data  = '0;
   endtask

   task automatic wait_drain(input int max_cycles);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d beats still owed after %0d cycles, required 0",
                  exp_q.size(), n);
      end
   endtask

   task automatic load4(input int a, input int b, input int c, input int d);
      line_buf[0] = pixel_t'(a);
      line_buf[1] = pixel_t'(b);
      line_buf[2] = pixel_t'(c);
      line_buf[3] = pixel_t'(d);
   endtask

   initial begin : watchdog
      #500000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : main
      int n;
      int gap;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      in_eol      = 1'b0;
      ready_mode  = 0;
      ready_level = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset out_valid", 32'(out_valid), 0);
      chk("reset out_data", 32'(out_data), 0);
      chk("reset out_sol_eol_rep", 32'({out_sol, out_eol, out_rep}), 0);
      chk("reset stickies", 32'({overflow, line_dropped}), 0);

      // Basic replay with first-beat latency.
      ready_level = 1'b1;
      load4(10, 20, 30, 40);
      send_line(4);
      idle_in();
      @(negedge clk);
      chk("latency T+1 out_valid", 32'(out_valid), 0);
      @(negedge clk);
      chk("latency T+2 out_valid", 32'(out_valid), 1);
      wait_drain(100);

      // Toggling backpressure.
      ready_mode = 1;
      send_line(4);
      idle_in();
      wait_drain(200);
      ready_mode = 0;

      // Both banks filled under full backpressure; the third line is dropped.
      ready_level = 1'b0;
      repeat (3) @(posedge clk);
      load4(100, 101, 102, 103);
      send_line(4);
      load4(200, 201, 202, 203);
      send_line(4);
      load4(300, 301, 302, 303);
      send_line(4);
      idle_in();
      repeat (6) @(negedge clk);
      chk("drop line_dropped", 32'(line_dropped), 1);
      chk("drop stalled out_valid", 32'(out_valid), 1);
      ready_level = 1'b1;
      wait_drain(200);
      repeat (20) @(negedge clk);

      // Over-long line is truncated to the bank size.
      for (int i = 0; i < 10; i++) line_buf[i] = pixel_t'(i + 1);
      send_line(10);
      idle_in();
      wait_drain(200);
      chk("overflow sticky", 32'(overflow), 1);

      // Reset in the middle of a replay, then a fresh line.
      load4(10, 20, 30, 40);
      send_line(4);
      idle_in();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(out_valid && out_ready && out_data == 20 && out_rep == 0) && n < 50);
      chk("reset point reached", 32'(n < 50), 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid-replay reset out_valid", 32'(out_valid), 0);
      chk("mid-replay reset overflow", 32'(overflow), 0);
      chk("mid-replay reset line_dropped", 32'(line_dropped), 0);
      line_buf[0] = pixel_t'(5);
      line_buf[1] = pixel_t'(6);
      line_buf[2] = pixel_t'(7);
      send_line(3);
      idle_in();
      wait_drain(100);

      // Extreme sample values.
      line_buf[0] = pixel_t'(-2048);
      line_buf[1] = pixel_t'(2047);
      line_buf[2] = pixel_t'(0);
      send_line(3);
      idle_in();
      wait_drain(100);

      // Random lines, random gaps, random backpressure.
      ready_mode = 2;
      for (int l = 0; l < 40; l++) begin
         n = $urandom_range(1, 10);
         for (int i = 0; i < n; i++) line_buf[i] = pixel_t'($urandom_range(0, 4095));
         send_line(n);
         gap = $urandom_range(0, 3);
         if (gap > 0) begin
            idle_in();
            repeat (gap - 1) @(posedge clk);
         end
      end
      idle_in();
      ready_mode  = 0;
      ready_level = 1'b1;
      wait_drain(2000);
      repeat (10) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
